goboard_info_writer: RTL and testbench

Text-console front end for the go-board info panel. Accepts a byte stream of ASCII characters and control codes over a valid/ready handshake, maintains a 16×32 cursor, and drives the write port of the info character RAM (`wea`, `write_ram_addr`, `in_char`) in the `sys_clk_in` domain. It sits directly upstream of the info-panel renderer, which reads the same RAM on the VGA clock.

---
 rtl/goboard_info_pkg.sv | 49 ++++
 rtl/goboard_info_cursor.sv | 84 ++++++++
 rtl/goboard_info_writer.sv | 195 +++++++++++++++++++
 tb/tb_goboard_info_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/goboard_info_pkg.sv
// goboard_info_pkg
// Shared definitions for the go-board info panel: text geometry, ASCII
// control codes, writer FSM state encoding and cursor operation codes.
// The info-panel renderer takes its geometry from this package as well.
// Build option: GOINFO_ROW_CLEAR_EN adds the CLR_ROW state to the encoding.
package goboard_info_pkg;

  localparam int INFO_COLS = 16;
  localparam int INFO_ROWS = 32;
  localparam int COL_W     = $clog2(INFO_COLS);
  localparam int ROW_W     = $clog2(INFO_ROWS);
  localparam int ADDR_W    = ROW_W + COL_W;
  localparam int CELLS     = INFO_COLS * INFO_ROWS;
  // One extra bit so the sweep can count one past the last cell.
  localparam int SWEEP_W   = ADDR_W + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(INFO_COLS - 1);

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] ASC_LF     = 8'h0A;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_BS     = 8'h08;
  localparam logic [7:0] ASC_FF     = 8'h0C;
  localparam logic [7:0] ASC_SPACE  = 8'h20;
  localparam logic [7:0] ASC_TILDE  = 8'h7E;

`ifdef GOINFO_ROW_CLEAR_EN
  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CLR_ROW = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_IDLE    = 2'd1
  } state_t;
`endif

  typedef enum logic [2:0] {
    CUR_HOLD    = 3'd0,
    CUR_ADVANCE = 3'd1,
    CUR_NEWLINE = 3'd2,
    CUR_RETURN  = 3'd3,
    CUR_BACK    = 3'd4,
    CUR_HOME    = 3'd5
  } cur_op_t;

endpackage

// File: rtl/goboard_info_cursor.sv
// goboard_info_cursor
// Row/column cursor for the info console.
// Ports:
//   i_clk, i_clr        clock, synchronous active-high reset (cursor -> 0,0)
//   i_op                cursor operation (cur_op_t encoding)
//   o_row, o_col        registered cursor position
//   o_next_row/col      position that takes effect at the next edge
//   o_row_entered       combinational pulse: i_op moves the cursor to a new row
module goboard_info_cursor
  import goboard_info_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [2:0]       i_op,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_next_row,
  output logic [COL_W-1:0] o_next_col,
  output logic             o_row_entered
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] w_next_row;
  logic [COL_W-1:0] w_next_col;
  logic             w_row_entered;

  // Next-position computation; the row field wraps naturally at INFO_ROWS.
  always_comb begin
    w_next_row    = r_row;
    w_next_col    = r_col;
    w_row_entered = 1'b0;
    case (i_op)
      CUR_ADVANCE: begin
        if (r_col == COL_LAST) begin
          w_next_col    = '0;
          w_next_row    = r_row + ROW_W'(1);
          w_row_entered = 1'b1;
        end else begin
          w_next_col = r_col + COL_W'(1);
        end
      end
      CUR_NEWLINE: begin
        w_next_col    = '0;
        w_next_row    = r_row + ROW_W'(1);
        w_row_entered = 1'b1;
      end
      CUR_RETURN: w_next_col = '0;
      CUR_BACK: begin
        if (r_col != '0) begin
          w_next_col = r_col - COL_W'(1);
        end else begin
          w_next_col = r_col;
        end
      end
      CUR_HOME: begin
        w_next_row = '0;
        w_next_col = '0;
      end
      default: begin
        w_next_row = r_row;
        w_next_col = r_col;
      end
    endcase
  end

  // Cursor position register.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_next_row;
      r_col <= w_next_col;
    end
  end

  assign o_row         = r_row;
  assign o_col         = r_col;
  assign o_next_row    = w_next_row;
  assign o_next_col    = w_next_col;
  assign o_row_entered = w_row_entered;

endmodule

// File: rtl/goboard_info_writer.sv
// goboard_info_writer
// Text-console front end: accepts bytes over valid/ready, keeps a 16x32
// cursor and drives the info character RAM write port.
// Ports:
//   sys_clk_in, clr               clock, synchronous active-high reset
//   char_valid, char_in, char_ready   byte handshake
//   wea, write_ram_addr, in_char  RAM write port, address = {row, col}
//   cursor_row, cursor_col        current cursor
//   busy                          clear sequence in progress (= ~char_ready)
// All outputs are registered. Build option GOINFO_ROW_CLEAR_EN: blank a row
// whenever the cursor enters it (CLR_ROW state).
module goboard_info_writer
  import goboard_info_pkg::*;
(
  input  logic        sys_clk_in,
  input  logic        clr,
  input  logic        char_valid,
  input  logic [7:0]  char_in,
  output logic        char_ready,
  output logic        wea,
  output logic [8:0]  write_ram_addr,
  output logic [7:0]  in_char,
  output logic [4:0]  cursor_row,
  output logic [3:0]  cursor_col,
  output logic        busy
);

  state_t              r_state, w_next_state;
  logic [SWEEP_W-1:0]  r_sweep, w_next_sweep;
  logic                r_wea, w_wea;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [7:0]          r_char, w_char;
  logic                r_ready, r_busy;

  cur_op_t             w_cur_op;
  logic [ROW_W-1:0]    w_row, w_next_row;
  logic [COL_W-1:0]    w_col, w_next_col;
  logic                w_row_entered;
  logic                w_accept;
  logic                w_printable;

  assign w_accept    = char_valid && r_ready;
  assign w_printable = (char_in >= ASC_SPACE) && (char_in <= ASC_TILDE);

  goboard_info_cursor u_cursor (
    .i_clk         (sys_clk_in),
    .i_clr         (clr),
    .i_op          (w_cur_op),
    .o_row         (w_row),
    .o_col         (w_col),
    .o_next_row    (w_next_row),
    .o_next_col    (w_next_col),
    .o_row_entered (w_row_entered)
  );

  // Cursor operation decode, kept apart from the FSM block because the FSM
  // consumes the cursor's row_entered/next-row results of this decode.
  always_comb begin
    w_cur_op = CUR_HOLD;
    if (r_state == ST_IDLE && w_accept) begin
      if (w_printable) begin
        w_cur_op = CUR_ADVANCE;
      end else begin
        case (char_in)
          ASC_LF:  w_cur_op = CUR_NEWLINE;
          ASC_CR:  w_cur_op = CUR_RETURN;
          ASC_BS:  w_cur_op = CUR_BACK;
          ASC_FF:  w_cur_op = CUR_HOME;
          default: w_cur_op = CUR_HOLD;
        endcase
      end
    end else begin
      w_cur_op = CUR_HOLD;
    end
  end

  // Next-state, sweep counter and write-port decode. Each sweep counts one
  // past its last cell so ready returns one cycle after the final write.
  always_comb begin
    w_next_state = r_state;
    w_next_sweep = r_sweep;
    w_wea        = 1'b0;
    w_addr       = r_addr;
    w_char       = r_char;
    case (r_state)
      ST_CLR_ALL: begin
        if (r_sweep == SWEEP_W'(CELLS)) begin
          w_next_state = ST_IDLE;
          w_next_sweep = '0;
        end else begin
          w_wea        = 1'b1;
          w_addr       = r_sweep[ADDR_W-1:0];
          w_char       = BLANK_CHAR;
          w_next_sweep = r_sweep + SWEEP_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_wea  = 1'b1;
            w_addr = {w_row, w_col};
            w_char = char_in;
`ifdef GOINFO_ROW_CLEAR_EN
            if (w_row_entered) begin
              w_next_state = ST_CLR_ROW;
              w_next_sweep = '0;
            end else begin
              w_next_state = ST_IDLE;
            end
`endif
          end else if (char_in == ASC_LF) begin
`ifdef GOINFO_ROW_CLEAR_EN
            // The first blank of the new row is written immediately.
            w_wea        = 1'b1;
            w_addr       = {w_next_row, {COL_W{1'b0}}};
            w_char       = BLANK_CHAR;
            w_next_state = ST_CLR_ROW;
            w_next_sweep = SWEEP_W'(1);
`else
            w_wea        = 1'b0;
`endif
          end else if (char_in == ASC_BS) begin
            if (w_col != '0) begin
              w_wea  = 1'b1;
              w_addr = {w_next_row, w_next_col};
              w_char = BLANK_CHAR;
            end else begin
              w_wea  = 1'b0;
            end
          end else if (char_in == ASC_FF) begin
            w_next_state = ST_CLR_ALL;
            w_next_sweep = '0;
          end else begin
            w_wea = 1'b0;
          end
        end else begin
          w_wea = 1'b0;
        end
      end
`ifdef GOINFO_ROW_CLEAR_EN
      ST_CLR_ROW: begin
        if (r_sweep == SWEEP_W'(INFO_COLS)) begin
          w_next_state = ST_IDLE;
          w_next_sweep = '0;
        end else begin
          w_wea        = 1'b1;
          w_addr       = {w_row, r_sweep[COL_W-1:0]};
          w_char       = BLANK_CHAR;
          w_next_sweep = r_sweep + SWEEP_W'(1);
        end
      end
`endif
      default: begin
        w_next_state = ST_CLR_ALL;
        w_next_sweep = '0;
      end
    endcase
  end

`ifndef GOINFO_ROW_CLEAR_EN
  // Without row clearing the row-entry pulse has no consumer.
  logic w_unused_row_entered;
  assign w_unused_row_entered = w_row_entered;
`endif

  // State, sweep and registered output port.
  always_ff @(posedge sys_clk_in) begin
    if (clr) begin
      r_state <= ST_CLR_ALL;
      r_sweep <= '0;
      r_wea   <= 1'b0;
      r_addr  <= '0;
      r_char  <= BLANK_CHAR;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_sweep <= w_next_sweep;
      r_wea   <= w_wea;
      r_addr  <= w_addr;
      r_char  <= w_char;
      r_ready <= (w_next_state == ST_IDLE);
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  assign char_ready     = r_ready;
  assign busy           = r_busy;
  assign wea            = r_wea;
  assign write_ram_addr = r_addr;
  assign in_char        = r_char;
  assign cursor_row     = w_row;
  assign cursor_col     = w_col;

endmodule

// File: tb/tb_goboard_info_writer.sv
// Directed bench for goboard_info_writer. Outputs are sampled on the falling
// edge; inputs change right after it. Expectations follow the build option
// GOINFO_ROW_CLEAR_EN when it is defined.
module tb_goboard_info_writer;

  logic       sys_clk_in;
  logic       clr;
  logic       char_valid;
  logic [7:0] char_in;
  logic       char_ready;
  logic       wea;
  logic [8:0] write_ram_addr;
  logic [7:0] in_char;
  logic [4:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  goboard_info_writer dut (
    .sys_clk_in     (sys_clk_in),
    .clr            (clr),
    .char_valid     (char_valid),
    .char_in        (char_in),
    .char_ready     (char_ready),
    .wea            (wea),
    .write_ram_addr (write_ram_addr),
    .in_char        (in_char),
    .cursor_row     (cursor_row),
    .cursor_col     (cursor_col),
    .busy           (busy)
  );

  initial sys_clk_in = 1'b0;
  always #5 sys_clk_in = ~sys_clk_in;

  task automatic tick();
    @(negedge sys_clk_in);
  endtask

  // Offer one byte for a single edge; returns in the cycle after acceptance.
  task automatic send(input logic [7:0] b);
    char_valid = 1'b1;
    char_in    = b;
    tick();
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    n_checks++;
    if (char_ready !== 1'b1) $display("FAIL %s: char_ready=%b after %0d cycles, want 1", tag, char_ready, limit);
    else n_pass++;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    n_checks++;
    if (wea !== 1'b0 || write_ram_addr !== 9'd0 || in_char !== 8'h20 || char_ready !== 1'b0 ||
        busy !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 4'd0)
      $display("FAIL reset_outputs: wea=%b addr=%0d data=%h rdy=%b busy=%b cur=(%0d,%0d), want 0/0/20/0/1/(0,0)",
               wea, write_ram_addr, in_char, char_ready, busy, cursor_row, cursor_col);
    else n_pass++;
    clr = 1'b0;
    for (int k = 0; k < 512; k++) begin
      tick();
      n_checks++;
      if (wea !== 1'b1 || write_ram_addr !== 9'(k) || in_char !== 8'h20 || char_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL clr_all_sweep: wea=%b addr=%0d data=%h rdy=%b busy=%b, want 1/%0d/20/0/1",
                 wea, write_ram_addr, in_char, char_ready, busy, k);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0 || wea !== 1'b0)
      $display("FAIL clr_all_done: rdy=%b busy=%b wea=%b, want 1/0/0", char_ready, busy, wea);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    char_valid = 1'b1;
    char_in    = 8'h41;
    tick();
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd0 || in_char !== 8'h41 || char_ready !== 1'b1)
      $display("FAIL ab_first: wea=%b addr=%0d data=%h rdy=%b, want 1/0/41/1", wea, write_ram_addr, in_char, char_ready);
    else n_pass++;
    char_in = 8'h42;
    tick();
    char_valid = 1'b0;
    char_in    = 8'h00;
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd1 || in_char !== 8'h42)
      $display("FAIL ab_second: wea=%b addr=%0d data=%h, want 1/1/42", wea, write_ram_addr, in_char);
    else n_pass++;
    n_checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 4'd2)
      $display("FAIL ab_cursor: cur=(%0d,%0d), want (0,2)", cursor_row, cursor_col);
    else n_pass++;
    tick();
    n_checks++;
    if (wea !== 1'b0) $display("FAIL ab_idle_wea: wea=%b, want 0", wea);
    else n_pass++;
  endtask

  task automatic test_wrap();
    // Fill columns 2..14 so the cursor lands on (0,15).
    for (int k = 0; k < 13; k++) send(8'h61 + 8'(k));
    n_checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 4'd15)
      $display("FAIL wrap_setup: cur=(%0d,%0d), want (0,15)", cursor_row, cursor_col);
    else n_pass++;
    send(8'h5A);
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd15 || in_char !== 8'h5A || cursor_row !== 5'd1 || cursor_col !== 4'd0)
      $display("FAIL wrap_write: wea=%b addr=%0d data=%h cur=(%0d,%0d), want 1/15/5a/(1,0)",
               wea, write_ram_addr, in_char, cursor_row, cursor_col);
    else n_pass++;
`ifdef GOINFO_ROW_CLEAR_EN
    n_checks++;
    if (char_ready !== 1'b0) $display("FAIL wrap_ready_low: rdy=%b, want 0", char_ready);
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++;
      if (wea !== 1'b1 || write_ram_addr !== 9'(16 + k) || in_char !== 8'h20 || char_ready !== 1'b0)
        $display("FAIL wrap_row_clear: wea=%b addr=%0d data=%h rdy=%b, want 1/%0d/20/0",
                 wea, write_ram_addr, in_char, char_ready, 16 + k);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (char_ready !== 1'b1 || wea !== 1'b0)
      $display("FAIL wrap_ready_back: rdy=%b wea=%b, want 1/0", char_ready, wea);
    else n_pass++;
`else
    n_checks++;
    if (char_ready !== 1'b1) $display("FAIL wrap_ready: rdy=%b, want 1", char_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (wea !== 1'b0) $display("FAIL wrap_no_clear: wea=%b, want 0", wea);
    else n_pass++;
`endif
  endtask

  task automatic test_lf_wrap();
    for (int k = 0; k < 30; k++) begin
      send(8'h0A);
      wait_ready(40, "lf_walk_ready");
    end
    for (int k = 0; k < 3; k++) send(8'h30 + 8'(k));
    n_checks++;
    if (cursor_row !== 5'd31 || cursor_col !== 4'd3)
      $display("FAIL lf_setup: cur=(%0d,%0d), want (31,3)", cursor_row, cursor_col);
    else n_pass++;
    send(8'h0A);
    n_checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 4'd0)
      $display("FAIL lf_cursor: cur=(%0d,%0d), want (0,0)", cursor_row, cursor_col);
    else n_pass++;
`ifdef GOINFO_ROW_CLEAR_EN
    for (int k = 0; k < 16; k++) begin
      if (k != 0) tick();
      n_checks++;
      if (wea !== 1'b1 || write_ram_addr !== 9'(k) || in_char !== 8'h20 || char_ready !== 1'b0)
        $display("FAIL lf_row_clear: wea=%b addr=%0d data=%h rdy=%b, want 1/%0d/20/0",
                 wea, write_ram_addr, in_char, char_ready, k);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (char_ready !== 1'b1 || wea !== 1'b0)
      $display("FAIL lf_ready_back: rdy=%b wea=%b, want 1/0", char_ready, wea);
    else n_pass++;
`else
    n_checks++;
    if (wea !== 1'b0 || char_ready !== 1'b1)
      $display("FAIL lf_no_write: wea=%b rdy=%b, want 0/1", wea, char_ready);
    else n_pass++;
`endif
  endtask

  task automatic test_backspace();
    send(8'h08);
    n_checks++;
    if (wea !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 4'd0 || char_ready !== 1'b1)
      $display("FAIL bs_col0: wea=%b cur=(%0d,%0d) rdy=%b, want 0/(0,0)/1", wea, cursor_row, cursor_col, char_ready);
    else n_pass++;
    send(8'h50);
    send(8'h51);
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd1 || in_char !== 8'h51)
      $display("FAIL bs_q_write: wea=%b addr=%0d data=%h, want 1/1/51", wea, write_ram_addr, in_char);
    else n_pass++;
    send(8'h08);
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd1 || in_char !== 8'h20 || cursor_row !== 5'd0 || cursor_col !== 4'd1)
      $display("FAIL bs_erase: wea=%b addr=%0d data=%h cur=(%0d,%0d), want 1/1/20/(0,1)",
               wea, write_ram_addr, in_char, cursor_row, cursor_col);
    else n_pass++;
    send(8'h0D);
    n_checks++;
    if (wea !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 4'd0)
      $display("FAIL cr_return: wea=%b cur=(%0d,%0d), want 0/(0,0)", wea, cursor_row, cursor_col);
    else n_pass++;
    send(8'h7E);
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd0 || in_char !== 8'h7E || cursor_col !== 4'd1)
      $display("FAIL tilde_write: wea=%b addr=%0d data=%h col=%0d, want 1/0/7e/1", wea, write_ram_addr, in_char, cursor_col);
    else n_pass++;
  endtask

  task automatic test_ff_reset();
    send(8'h0C);
    n_checks++;
    if (wea !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 4'd0)
      $display("FAIL ff_accept: wea=%b rdy=%b busy=%b cur=(%0d,%0d), want 0/0/1/(0,0)",
               wea, char_ready, busy, cursor_row, cursor_col);
    else n_pass++;
    for (int k = 0; k < 100; k++) tick();
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd99 || in_char !== 8'h20)
      $display("FAIL ff_sweep_mid: wea=%b addr=%0d data=%h, want 1/99/20", wea, write_ram_addr, in_char);
    else n_pass++;
    clr = 1'b1;
    tick();
    n_checks++;
    if (wea !== 1'b0 || write_ram_addr !== 9'd0 || in_char !== 8'h20 || char_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL ff_clr_outputs: wea=%b addr=%0d data=%h rdy=%b busy=%b, want 0/0/20/0/1",
               wea, write_ram_addr, in_char, char_ready, busy);
    else n_pass++;
    clr = 1'b0;
    tick();
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd0)
      $display("FAIL ff_restart0: wea=%b addr=%0d, want 1/0", wea, write_ram_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (wea !== 1'b1 || write_ram_addr !== 9'd1)
      $display("FAIL ff_restart1: wea=%b addr=%0d, want 1/1", wea, write_ram_addr);
    else n_pass++;
    wait_ready(600, "ff_sweep_done");
    send(8'h07);
    n_checks++;
    if (wea !== 1'b0 || char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 4'd0)
      $display("FAIL bel_dropped: wea=%b rdy=%b cur=(%0d,%0d), want 0/1/(0,0)", wea, char_ready, cursor_row, cursor_col);
    else n_pass++;
  endtask

  initial begin
    clr        = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_lf_wrap();
    test_backspace();
    test_ff_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
